seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 173 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter (Moore FSM), MSB-first, programmable repeats
//
// Purpose: shifts a PAT_W-bit pattern out on x, one bit per clock, R = repeat_cnt+1
//          times. The stream feeds the overlapping "1001" sequence detector.
// Optional feature macro: SEQ_PATTERN_TX_GAP_EN
//          defined   -> GAP_LEN zero bits (valid=1) separate repetitions
//          undefined -> repetitions are sent back-to-back
// Ports:
//   clk         clock, all logic on posedge
//   clear_n     synchronous active-low reset
//   start       begin a transmission (sampled only in IDLE)
//   repeat_cnt  repetitions minus 1, sampled with start
//   pat_load    load pat_in into the pattern register (IDLE only)
//   pat_in      new pattern value
//   abort       terminate a transmission in SEND/GAP without done
//   x           serial data bit
//   valid       x carries a pattern or gap bit
//   frame       high on the MSB of each repetition
//   busy        FSM is in SEND or GAP
//   done        one-cycle pulse after the final bit
module seq_pattern_tx #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
    parameter int               CNT_W   = 4,
    parameter int               GAP_LEN = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             abort,
    output logic             x,
    output logic             valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    localparam int             IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;      // programmable pattern register
    logic [PAT_W-1:0] snap_q;     // pattern frozen for the in-flight transmission
    logic [IDX_W-1:0] bit_idx_q;  // index of the bit currently on x
    logic [CNT_W-1:0] reps_q;     // repetitions still to send after the current one
    logic             x_q, valid_q, frame_q, busy_q, done_q;

`ifdef SEQ_PATTERN_TX_GAP_EN
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    logic [GAP_W-1:0] gap_q;      // gap cycles remaining after the current one
`else
    localparam int unused_gap_len = GAP_LEN;
`endif

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q   <= S_IDLE;
            pat_q     <= PATTERN;
            snap_q    <= '0;
            bit_idx_q <= '0;
            reps_q    <= '0;
            x_q       <= 1'b0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_PATTERN_TX_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    x_q     <= 1'b0;
                    valid_q <= 1'b0;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (pat_load) pat_q <= pat_in;
                    if (start) begin
                        // A simultaneous load wins: the transmission uses pat_in.
                        snap_q    <= pat_load ? pat_in : pat_q;
                        x_q       <= pat_load ? pat_in[PAT_W-1] : pat_q[PAT_W-1];
                        reps_q    <= repeat_cnt;
                        bit_idx_q <= MSB_IDX;
                        valid_q   <= 1'b1;
                        frame_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        x_q     <= 1'b0;
                        valid_q <= 1'b0;
                        frame_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (bit_idx_q != '0) begin
                        bit_idx_q <= bit_idx_q - 1'b1;
                        x_q       <= snap_q[bit_idx_q - 1'b1];
                        frame_q   <= 1'b0;
                    end else if (reps_q != '0) begin
                        reps_q <= reps_q - 1'b1;
`ifdef SEQ_PATTERN_TX_GAP_EN
                        if (GAP_LEN > 0) begin
                            state_q <= S_GAP;
                            gap_q   <= GAP_W'(GAP_LEN - 1);
                            x_q     <= 1'b0;
                            frame_q <= 1'b0;
                        end else
`endif
                        begin
                            bit_idx_q <= MSB_IDX;
                            x_q       <= snap_q[PAT_W-1];
                            frame_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= S_DONE;
                        x_q     <= 1'b0;
                        valid_q <= 1'b0;
                        frame_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`ifdef SEQ_PATTERN_TX_GAP_EN
                S_GAP: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else begin
                        state_q   <= S_SEND;
                        bit_idx_q <= MSB_IDX;
                        x_q       <= snap_q[PAT_W-1];
                        frame_q   <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    x_q     <= 1'b0;
                    valid_q <= 1'b0;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    x_q     <= 1'b0;
                    valid_q <= 1'b0;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x     = x_q;
    assign valid = valid_q;
    assign frame = frame_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard testbench for seq_pattern_tx
module tb_seq_pattern_tx;

    localparam int GAP_LEN = 1;
`ifdef SEQ_PATTERN_TX_GAP_EN
    localparam int GAP_EFF = GAP_LEN;
`else
    localparam int GAP_EFF = 0;
`endif

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] repeat_cnt = '0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = '0;
    logic       abort = 1'b0;
    logic       x, valid, frame, busy, done;

    // {x, valid, frame, busy, done}
    typedef logic [4:0] out_t;
    out_t exp_q[$];
    out_t got, e;
    int   total = 0;
    int   bad   = 0;

    localparam out_t IDLE_O = 5'b00000;
    localparam out_t DONE_O = 5'b00001;
    localparam out_t GAP_O  = 5'b01010;

    seq_pattern_tx #(
        .PAT_W(4), .PATTERN(4'b1001), .CNT_W(4), .GAP_LEN(GAP_LEN)
    ) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .repeat_cnt(repeat_cnt),
        .pat_load(pat_load), .pat_in(pat_in), .abort(abort),
        .x(x), .valid(valid), .frame(frame), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference stream for a complete transmission, followed by one idle cycle.
    task automatic push_frame(input logic [3:0] pat, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int b = 3; b >= 0; b--)
                exp_q.push_back({pat[b], 1'b1, (b == 3), 1'b1, 1'b0});
            if (r != reps - 1)
                for (int g = 0; g < GAP_EFF; g++) exp_q.push_back(GAP_O);
        end
        exp_q.push_back(DONE_O);
        exp_q.push_back(IDLE_O);
    endtask

    task automatic test_reset();
        int n;
        clear_n = 1'b0;
        start   = 1'b1;
        exp_q.push_back(IDLE_O);
        exp_q.push_back(IDLE_O);
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL reset cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
        clear_n    = 1'b1;
        repeat_cnt = 4'd0;
        push_frame(4'b1001, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL reset_release cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
    endtask

    task automatic test_single();
        int n;
        int busy_cnt = 0;
        start      = 1'b1;
        repeat_cnt = 4'd0;
        push_frame(4'b1001, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL single cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
        total++;
        if (busy_cnt !== 4) begin
            $display("FAIL single_busy got=%0d want=4", busy_cnt);
            bad++;
        end
    endtask

    task automatic test_repeats(input logic [3:0] rc);
        int n;
        int busy_cnt = 0;
        int det = 0;
        int reps;
        logic [3:0] sh = '0;
        reps       = int'(rc) + 1;
        start      = 1'b1;
        repeat_cnt = rc;
        push_frame(4'b1001, reps);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            sh = {sh[2:0], x};
            if (sh == 4'b1001) det++;
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL repeats rc=%0d cyc=%0d got=%b want=%b", rc, i, got, e);
                bad++;
            end
        end
        total++;
        if (busy_cnt !== reps * 4 + (reps - 1) * GAP_EFF) begin
            $display("FAIL repeats_busy rc=%0d got=%0d want=%0d", rc, busy_cnt,
                     reps * 4 + (reps - 1) * GAP_EFF);
            bad++;
        end
        total++;
        if (det !== reps) begin
            $display("FAIL repeats_detect rc=%0d got=%0d want=%0d", rc, det, reps);
            bad++;
        end
    endtask

    task automatic test_load_with_start();
        int n;
        start      = 1'b1;
        pat_load   = 1'b1;
        pat_in     = 4'b0110;
        repeat_cnt = 4'd0;
        push_frame(4'b0110, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start    = 1'b0;
            pat_load = 1'b0;
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL load_with_start cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
    endtask

    task automatic test_pattern_load();
        int n;
        pat_load = 1'b1;
        pat_in   = 4'b1101;
        exp_q.push_back(IDLE_O);
        push_frame(4'b1101, 1);
        push_frame(4'b1101, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            pat_load = 1'b0;
            start    = 1'b0;
            if (i == 0) start = 1'b1;
            if (i == 2) begin
                pat_load = 1'b1;
                pat_in   = 4'b0000;
            end
            if (i == 6) start = 1'b1;
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL pattern_load cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
    endtask

    task automatic test_abort();
        int n;
        start      = 1'b1;
        repeat_cnt = 4'd0;
        exp_q.push_back(5'b11110);
        exp_q.push_back(5'b11010);
        for (int k = 0; k < 3; k++) exp_q.push_back(IDLE_O);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            abort = (i == 1);
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL abort cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_collision();
        int n;
        start      = 1'b1;
        repeat_cnt = 4'd0;
        push_frame(4'b1101, 1);
        for (int k = 0; k < 3; k++) exp_q.push_back(IDLE_O);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start      = (i == 1) || (i == 3);
            repeat_cnt = 4'd3;
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL collision cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
        start      = 1'b0;
        repeat_cnt = 4'd0;
    endtask

    task automatic test_reset_mid();
        int n;
        start = 1'b1;
        exp_q.push_back(5'b11110);
        exp_q.push_back(5'b11010);
        exp_q.push_back(5'b01010);
        for (int k = 0; k < 3; k++) exp_q.push_back(IDLE_O);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start   = 1'b0;
            clear_n = (i != 2);
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL reset_mid cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
        clear_n = 1'b1;
        start   = 1'b1;
        push_frame(4'b1001, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            got = {x, valid, frame, busy, done};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                $display("FAIL reset_restore cyc=%0d got=%b want=%b", i, got, e);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeats(4'd2);
        test_repeats(4'd15);
        test_load_with_start();
        test_pattern_load();
        test_abort();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
